fifo_stream_reader: RTL

- Read-side companion for the team's FIFOs. Sits in the FIFO read clock domain and drives the FIFO's rd_en.
- The FIFO returns registered read data one cycle after an accepted read. This block absorbs that latency with a small prefetch buffer.
- Presents a valid/ready stream downstream, with full throughput, a flush input and a transfer counter.

---
 rtl/fifo_stream_reader_pkg.sv | 19 +
 rtl/stream_ring_buf.sv | 59 +++++
 rtl/fifo_stream_reader.sv | 79 +++++++
 3 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
// Defaults match the FIFO library so both sides agree on word width and depth.
package fifo_stream_reader_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_BUF_DEPTH   = 4;
    localparam int DEFAULT_COUNT_WIDTH = 16;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_ring_buf.sv
// Small ring buffer holding prefetched FIFO words. Push writes at the write
// index, pop advances the read index, flush empties it in one cycle. The
// head entry is always visible on head_data; occ says whether it is valid.
module stream_ring_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      pop,
    output logic [clog2(BUF_DEPTH):0] occ,
    output logic [DATA_WIDTH-1:0]     head_data
);

    localparam int IDX_WIDTH = clog2(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic [IDX_WIDTH-1:0]  rd_idx;

    // Write the landing word into the slot at the write index.
    // NOTE: storage has no reset; occ alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Advance indices and track occupancy; flush and reset empty the ring.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_idx <= '0;
            rd_idx <= '0;
            occ    <= '0;
        end else begin
            // Power-of-two depth lets the indices wrap by natural overflow.
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (!push && pop) begin
                occ <= occ - 1'b1;
            end
        end
    end

    assign head_data = mem[rd_idx];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side companion for the team FIFOs. Issues fifo_rd_en only when a
// buffer slot is reserved for the returning word, absorbs the one-cycle
// FIFO read latency in a ring buffer, and presents a valid/ready stream
// with a flush control and a wrapping transfer counter.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH   = DEFAULT_BUF_DEPTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    input  logic                   flush,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] xfer_count
);

    localparam int OCC_WIDTH = clog2(BUF_DEPTH) + 1;
    localparam logic [OCC_WIDTH:0] DEPTH_LIMIT = (OCC_WIDTH + 1)'(BUF_DEPTH);

    logic [OCC_WIDTH-1:0] occ;
    logic [OCC_WIDTH:0]   reserved;
    logic                 inflight;
    logic                 discard;
    logic                 land;
    logic                 pop;

    // Slots already claimed: buffered words plus the word still returning.
    assign reserved = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight};

    // Read only when a slot is free for the returning word; m_ready is
    // deliberately kept out of this path so no combinational loop forms
    // between the downstream sink and the FIFO.
    assign fifo_rd_en = !rst && !flush && !fifo_empty && (reserved < DEPTH_LIMIT);

    // A returning word is kept unless it lands during or just after a flush.
    assign land    = inflight && !discard && !flush;
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;
    assign busy    = m_valid || inflight;

    // Track the outstanding read, the post-flush drop window and accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= 1'b0;
            discard    <= 1'b0;
            xfer_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            discard  <= flush && fifo_rd_en;
            // A beat accepted in the same cycle as a flush still counts.
            if (pop) begin
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end

    stream_ring_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (land),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

endmodule
